// File: rtl/srtc_pkg.sv
// Shared definitions for the S-RTC register engine: state encoding, command
// nibbles and field geometry.
package srtc_pkg;

  localparam int unsigned SRTC_NIBBLES = 13;
  localparam int unsigned NIB_W        = 4;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned TIME_W       = NIB_W * SRTC_NIBBLES;

  localparam logic [NIB_W-1:0] CMD_READ  = 4'hD;
  localparam logic [NIB_W-1:0] CMD_CMD   = 4'hE;
  localparam logic [NIB_W-1:0] CMD_NOP   = 4'hF;
  localparam logic [NIB_W-1:0] SUB_WRITE = 4'h0;
  localparam logic [NIB_W-1:0] SUB_CLEAR = 4'h4;

  // rd_idx value meaning "next read returns the sync byte"
  localparam logic [IDX_W-1:0] RD_SYNC = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_COMMAND = 2'd2,
    ST_WRITE   = 2'd3
  } srtc_state_e;

endpackage

// File: rtl/srtc_nibble_file.sv
// 4-bit x NIBBLES time register: MCU bulk load beats clear beats a single
// nibble write; combinational nibble read mux.
module srtc_nibble_file
  import srtc_pkg::*;
#(
  parameter int unsigned NIBBLES = SRTC_NIBBLES
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_load,
  input  logic [NIB_W*NIBBLES-1:0] i_load_data,
  input  logic                     i_clear,
  input  logic                     i_wr_en,
  input  logic [IDX_W-1:0]         i_wr_idx,
  input  logic [NIB_W-1:0]         i_wr_data,
  input  logic [IDX_W-1:0]         i_rd_idx,
  output logic [NIB_W*NIBBLES-1:0] o_time,
  output logic [NIB_W-1:0]         o_rd_nib_c
);

  logic [NIB_W*NIBBLES-1:0] r_time;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_time <= '0;
    end else if (i_load) begin
      r_time <= i_load_data;
    end else if (i_clear) begin
      r_time <= '0;
    end else if (i_wr_en) begin
      for (int i = 0; i < int'(NIBBLES); i++) begin
        if (i_wr_idx == IDX_W'(i)) begin
          r_time[NIB_W*i +: NIB_W] <= i_wr_data;
        end
      end
    end
  end

  // Out-of-range indices read as zero; the FSM never selects them.
  always_comb begin
    o_rd_nib_c = '0;
    for (int i = 0; i < int'(NIBBLES); i++) begin
      if (i_rd_idx == IDX_W'(i)) begin
        o_rd_nib_c = r_time[NIB_W*i +: NIB_W];
      end
    end
  end

  assign o_time = r_time;

endmodule

// File: rtl/srtc_regs.sv
// S-RTC register engine: nibble-serial SNES read/write protocol over the
// BCD time register owned by the MCU.
module srtc_regs
  import srtc_pkg::*;
#(
  parameter int unsigned NIBBLES   = SRTC_NIBBLES,
  parameter logic [7:0]  IDLE_DATA = 8'h0F
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     srtc_enable,
  input  logic                     SNES_A0,
  input  logic                     snes_rd_strobe,
  input  logic                     snes_wr_strobe,
  input  logic [7:0]               DATA_IN,
  output logic [7:0]               DATA_OUT,
  input  logic [NIB_W*NIBBLES-1:0] rtc_data_in,
  input  logic                     rtc_we,
  output logic [NIB_W*NIBBLES-1:0] rtc_data_out,
  output logic                     rtc_dirty
);

  srtc_state_e      r_state, w_state_nx;
  logic [IDX_W-1:0] r_rd_idx, w_rd_idx_nx;
  logic [IDX_W-1:0] r_wr_idx, w_wr_idx_nx;
  logic [7:0]       r_data_out, w_data_out_nx;
  logic             r_dirty, w_dirty_nx;

  logic             w_rd, w_wr;
  logic [NIB_W-1:0] w_nib;
  logic [NIB_W-1:0] w_rd_nib;
  logic             w_clear, w_nib_we;
  logic             w_unused;

  assign w_rd     = srtc_enable & snes_rd_strobe & ~SNES_A0;
  assign w_wr     = srtc_enable & snes_wr_strobe & SNES_A0;
  assign w_nib    = DATA_IN[NIB_W-1:0];
  assign w_unused = ^DATA_IN[7:NIB_W];

  srtc_nibble_file #(
    .NIBBLES (NIBBLES)
  ) u_file (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_load      (rtc_we),
    .i_load_data (rtc_data_in),
    .i_clear     (w_clear),
    .i_wr_en     (w_nib_we),
    .i_wr_idx    (r_wr_idx),
    .i_wr_data   (w_nib),
    .i_rd_idx    (r_rd_idx),
    .o_time      (rtc_data_out),
    .o_rd_nib_c  (w_rd_nib)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_rd_idx   <= '0;
      r_wr_idx   <= '0;
      r_data_out <= IDLE_DATA;
      r_dirty    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_rd_idx   <= w_rd_idx_nx;
      r_wr_idx   <= w_wr_idx_nx;
      r_data_out <= w_data_out_nx;
      r_dirty    <= w_dirty_nx;
    end
  end

  // Writes take precedence over reads; the two are exclusive by address anyway.
  always_comb begin
    w_state_nx    = r_state;
    w_rd_idx_nx   = r_rd_idx;
    w_wr_idx_nx   = r_wr_idx;
    w_data_out_nx = r_data_out;
    w_dirty_nx    = 1'b0;
    w_clear       = 1'b0;
    w_nib_we      = 1'b0;

    if (w_wr) begin
      if (w_nib == CMD_READ) begin
        w_state_nx  = ST_READ;
        w_rd_idx_nx = RD_SYNC;
      end else if (w_nib == CMD_CMD) begin
        w_state_nx = ST_COMMAND;
      end else if (w_nib != CMD_NOP) begin
        case (r_state)
          ST_COMMAND: begin
            if (w_nib == SUB_WRITE) begin
              w_state_nx  = ST_WRITE;
              w_wr_idx_nx = '0;
            end else if (w_nib == SUB_CLEAR) begin
              w_clear    = 1'b1;
              w_state_nx = ST_IDLE;
            end else begin
              w_state_nx = ST_IDLE;
            end
          end
          ST_WRITE: begin
            w_nib_we = 1'b1;
            if (r_wr_idx == IDX_W'(NIBBLES - 1)) begin
              w_state_nx  = ST_IDLE;
              w_wr_idx_nx = '0;
              w_dirty_nx  = 1'b1;
            end else begin
              w_wr_idx_nx = r_wr_idx + IDX_W'(1);
            end
          end
          default: begin
          end
        endcase
      end
    end else if (w_rd) begin
      if (r_state == ST_READ) begin
        if (r_rd_idx == RD_SYNC) begin
          w_data_out_nx = 8'h0F;
          w_rd_idx_nx   = '0;
        end else if (r_rd_idx < IDX_W'(NIBBLES)) begin
          w_data_out_nx = {4'h0, w_rd_nib};
          w_rd_idx_nx   = r_rd_idx + IDX_W'(1);
        end else begin
          w_data_out_nx = 8'h0F;
          w_state_nx    = ST_IDLE;
        end
      end else begin
        w_data_out_nx = IDLE_DATA;
      end
    end
  end

  assign DATA_OUT  = r_data_out;
  assign rtc_dirty = r_dirty;

endmodule

// File: tb/tb_srtc_regs.sv
// Scoreboard bench for srtc_regs: directed protocol sequences plus random
// traffic, checked every cycle against a behavioural protocol model.
module tb_srtc_regs;

  logic        CLK = 1'b0;
  logic        RST;
  logic        srtc_enable, SNES_A0, snes_rd_strobe, snes_wr_strobe;
  logic [7:0]  DATA_IN;
  logic [7:0]  DATA_OUT;
  logic [51:0] rtc_data_in;
  logic        rtc_we;
  logic [51:0] rtc_data_out;
  logic        rtc_dirty;

  always #5 CLK = ~CLK;

  srtc_regs dut (
    .CLK            (CLK),
    .RST            (RST),
    .srtc_enable    (srtc_enable),
    .SNES_A0        (SNES_A0),
    .snes_rd_strobe (snes_rd_strobe),
    .snes_wr_strobe (snes_wr_strobe),
    .DATA_IN        (DATA_IN),
    .DATA_OUT       (DATA_OUT),
    .rtc_data_in    (rtc_data_in),
    .rtc_we         (rtc_we),
    .rtc_data_out   (rtc_data_out),
    .rtc_dirty      (rtc_dirty)
  );

  typedef struct {
    logic [7:0]  dout;
    logic        dirty;
    logic [51:0] tm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  // Protocol model: mode 0=idle 1=reading 2=awaiting command 3=collecting nibbles
  int         mode, ridx, widx;
  logic [3:0] tm [13];
  logic [7:0] dout;
  bit         dirty;

  function automatic logic [51:0] pack_tm();
    logic [51:0] v;
    for (int i = 0; i < 13; i++) v[4*i +: 4] = tm[i];
    return v;
  endfunction

  task automatic model(input bit rst, input bit en, input bit a0, input bit rds,
                       input bit wrs, input logic [7:0] din, input bit we,
                       input logic [51:0] ld);
    logic [3:0] n;
    logic [3:0] nt [13];
    bit wr, rd;
    if (rst) begin
      mode = 0; ridx = 0; widx = 0; dout = 8'h0F; dirty = 0;
      for (int i = 0; i < 13; i++) tm[i] = 4'h0;
      return;
    end
    n  = din[3:0];
    wr = en && wrs && a0;
    rd = en && rds && !a0 && !wr;
    for (int i = 0; i < 13; i++) nt[i] = tm[i];
    dirty = 0;
    if (wr) begin
      if (n == 4'hD) begin
        mode = 1; ridx = 15;
      end else if (n == 4'hE) begin
        mode = 2;
      end else if (n != 4'hF) begin
        if (mode == 2) begin
          if (n == 4'h0) begin mode = 3; widx = 0; end
          else if (n == 4'h4) begin
            for (int i = 0; i < 13; i++) nt[i] = 4'h0;
            mode = 0;
          end else mode = 0;
        end else if (mode == 3) begin
          nt[widx] = n;
          if (widx == 12) begin mode = 0; widx = 0; dirty = 1; end
          else widx++;
        end
      end
    end
    if (rd) begin
      if (mode == 1) begin
        if (ridx == 15) begin dout = 8'h0F; ridx = 0; end
        else if (ridx < 13) begin dout = {4'h0, tm[ridx]}; ridx++; end
        else begin dout = 8'h0F; mode = 0; end
      end else dout = 8'h0F;
    end
    if (we) for (int i = 0; i < 13; i++) nt[i] = ld[4*i +: 4];
    for (int i = 0; i < 13; i++) tm[i] = nt[i];
  endtask

  task automatic step(input bit rst, input bit en, input bit a0, input bit rds,
                      input bit wrs, input logic [7:0] din, input bit we,
                      input logic [51:0] ld);
    exp_t e;
    @(negedge CLK);
    #1;
    RST = rst; srtc_enable = en; SNES_A0 = a0; snes_rd_strobe = rds;
    snes_wr_strobe = wrs; DATA_IN = din; rtc_we = we; rtc_data_in = ld;
    @(posedge CLK);
    model(rst, en, a0, rds, wrs, din, we, ld);
    e.dout = dout; e.dirty = dirty; e.tm = pack_tm();
    q.push_back(e);
  endtask

  task automatic wr_nib(input logic [3:0] n);
    step(0, 1, 1, 0, 1, {4'h0, n}, 0, '0);
  endtask
  task automatic rd_op();
    step(0, 1, 0, 1, 0, 8'h00, 0, '0);
  endtask
  task automatic idle();
    step(0, 0, 0, 0, 0, 8'h00, 0, '0);
  endtask
  task automatic load(input logic [51:0] v);
    step(0, 0, 0, 0, 0, 8'h00, 1, v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("data_out", 64'(DATA_OUT), 64'(e.dout));
      chk("rtc_dirty", 64'(rtc_dirty), 64'(e.dirty));
      chk("rtc_data_out", 64'(rtc_data_out), 64'(e.tm));
    end
  end

  initial begin
    logic [63:0] rv;
    logic [3:0]  pick;
    int          k;
    bit          en, a0, rds, wrs, we, rst;

    RST = 1'b1; srtc_enable = 0; SNES_A0 = 0; snes_rd_strobe = 0;
    snes_wr_strobe = 0; DATA_IN = '0; rtc_we = 0; rtc_data_in = '0;

    // reset, then read in idle
    step(1, 0, 0, 0, 0, 8'h00, 0, '0);
    step(1, 0, 0, 0, 0, 8'h00, 0, '0);
    idle();
    rd_op();

    // MCU load, full read-out and one read past the end
    load(52'h1_20_12_31_23_59_59);
    wr_nib(4'hD);
    for (int i = 0; i < 16; i++) rd_op();
    idle();

    // complete 13-nibble write
    wr_nib(4'hE); wr_nib(4'h0);
    for (int i = 0; i < 13; i++) wr_nib(4'((i < 10) ? i : i - 10));
    idle(); idle();

    // write aborted after 5 nibbles
    wr_nib(4'hE); wr_nib(4'h0);
    for (int i = 0; i < 5; i++) wr_nib(4'(9 - i));
    wr_nib(4'hD);
    idle(); idle();
    wr_nib(4'hE); wr_nib(4'h7);
    rd_op();

    // MCU load colliding with the 3rd nibble write
    wr_nib(4'hE); wr_nib(4'h0);
    wr_nib(4'h1); wr_nib(4'h2);
    step(0, 1, 1, 0, 1, 8'h03, 1, 52'hA_BCDE_F012_3456);
    wr_nib(4'h8);
    wr_nib(4'hF);
    wr_nib(4'h9);

    // clear, clear colliding with load, ignored strobes
    wr_nib(4'hE); wr_nib(4'h4);
    load(52'h9_8765_4321_0987);
    wr_nib(4'hE);
    step(0, 1, 1, 0, 1, 8'h04, 1, 52'h1_1111_2222_3333);
    wr_nib(4'hD);
    step(0, 0, 0, 1, 0, 8'h00, 0, '0);
    step(0, 1, 1, 1, 0, 8'h00, 0, '0);
    step(0, 0, 1, 0, 1, 8'h0E, 0, '0);
    rd_op(); rd_op();
    step(0, 1, 0, 0, 1, 8'hF4, 0, '0);
    rd_op();

    // reset mid-read
    wr_nib(4'hD); rd_op(); rd_op(); rd_op();
    step(1, 1, 0, 1, 0, 8'h00, 0, '0);
    idle();
    rd_op();

    // random traffic
    for (int it = 0; it < 1500; it++) begin
      rst = ($urandom_range(0, 299) == 0);
      en  = ($urandom_range(0, 9) != 0);
      a0  = $urandom_range(0, 1);
      k   = $urandom_range(0, 3);
      rds = (k == 1) || (k == 3);
      wrs = (k == 2) || (k == 3);
      k   = $urandom_range(0, 19);
      if (k == 0) pick = 4'hD;
      else if (k == 1) pick = 4'hE;
      else if (k == 2) pick = 4'h0;
      else if (k == 3) pick = 4'h4;
      else pick = 4'($urandom_range(0, 15));
      we  = ($urandom_range(0, 39) == 0);
      rv  = {$urandom(), $urandom()};
      step(rst, en, a0, rds, wrs, {4'($urandom_range(0, 15)), pick}, we, rv[51:0]);
    end

    idle();
    @(negedge CLK);
    #2;
    chk("scoreboard_drain", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
